// File: rtl/calc_arbiter_pkg.sv
// Shared constants and types for the calculator sequencer/arbiter.
// Operation codes match the calculator's MODO input.
package calc_pkg;

  localparam int CALC_DATA_W = 4;

  localparam logic [1:0] MODO_ADD = 2'b00;
  localparam logic [1:0] MODO_SUB = 2'b01;
  localparam logic [1:0] MODO_MUL = 2'b10;
  localparam logic [1:0] MODO_SHL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_RESP    = 2'd3
  } state_e;

endpackage

// File: rtl/calc_arbiter_if.sv
// Request, calculator and response channels of the arbiter.
// The slave modport is the arbiter; master is requesters + calculator + consumer.
interface calc_arbiter_if
  import calc_pkg::*;
#(
  parameter int DATA_W = CALC_DATA_W
) ();

  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [1:0]        req0_modo;
  logic [1:0]        req1_modo;

  logic [DATA_W-1:0] calc_a;
  logic [DATA_W-1:0] calc_b;
  logic [1:0]        calc_modo;
  logic [DATA_W-1:0] calc_c;
  logic              calc_rco;

  logic              resp_valid;
  logic              resp_ready;
  logic              resp_id;
  logic [DATA_W-1:0] resp_c;
  logic              resp_rco;

  modport slave (
    input  req_valid, req0_a, req0_b, req1_a, req1_b, req0_modo, req1_modo,
    output req_ready,
    output calc_a, calc_b, calc_modo,
    input  calc_c, calc_rco,
    output resp_valid, resp_id, resp_c, resp_rco,
    input  resp_ready
  );

  modport master (
    output req_valid, req0_a, req0_b, req1_a, req1_b, req0_modo, req1_modo,
    input  req_ready,
    input  calc_a, calc_b, calc_modo,
    output calc_c, calc_rco,
    input  resp_valid, resp_id, resp_c, resp_rco,
    output resp_ready
  );

endinterface

// File: rtl/calc_arbiter_rr_arb2.sv
// Two-way round-robin grant: combinational from req and last winner,
// the last winner is remembered when a request is accepted.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic       grant,
  output logic       grant_valid
);

  logic last_reg;

  always_comb begin
    grant_valid = |req;
    // On a tie the requester that did not win last time goes first.
    if (req == 2'b11) grant = ~last_reg;
    else              grant = req[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_reg <= 1'b1;
    else if (accept) last_reg <= grant;
  end

endmodule

// File: rtl/calc_arbiter.sv
// Shares one registered calculator between two requesters: accept, issue,
// capture the result one cycle later, then hold it until the consumer takes it.
module calc_arbiter
  import calc_pkg::*;
#(
  parameter int DATA_W = CALC_DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  calc_arbiter_if.slave    bus,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_e            state_reg, state_next;
  logic              grant, grant_valid, accept, resp_fire, drive_calc;
  logic [DATA_W-1:0] op_a_reg, op_b_reg, resp_c_reg;
  logic [1:0]        op_modo_reg;
  logic              op_id_reg, resp_id_reg, resp_rco_reg;
  logic [CNT_W-1:0]  count_reg;

  rr_arb2 u_arb (
    .clk         (clk),
    .rst         (rst),
    .req         (bus.req_valid),
    .accept      (accept),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  // Ready is withheld while rst is high so it reads 0 during reset.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_ready
      assign bus.req_ready[gi] = (state_reg == ST_IDLE) && !rst && grant_valid
                                 && (grant == 1'(gi));
    end
  endgenerate

  assign accept = |(bus.req_valid & bus.req_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    drive_calc = 1'b0;
    resp_fire  = 1'b0;
    case (state_reg)
      ST_IDLE:    if (accept) state_next = ST_ISSUE;
      ST_ISSUE: begin
        drive_calc = 1'b1;
        state_next = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        drive_calc = 1'b1;
        state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_fire = bus.resp_ready;
        if (resp_fire) state_next = ST_IDLE;
      end
      default:    state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a_reg     <= '0;
      op_b_reg     <= '0;
      op_modo_reg  <= '0;
      op_id_reg    <= 1'b0;
      resp_c_reg   <= '0;
      resp_rco_reg <= 1'b0;
      resp_id_reg  <= 1'b0;
      count_reg    <= '0;
    end else begin
      if (accept) begin
        op_a_reg    <= grant ? bus.req1_a    : bus.req0_a;
        op_b_reg    <= grant ? bus.req1_b    : bus.req0_b;
        op_modo_reg <= grant ? bus.req1_modo : bus.req0_modo;
        op_id_reg   <= grant;
      end
      // The calculator's output register is valid during CAPTURE.
      if (state_reg == ST_CAPTURE) begin
        resp_c_reg   <= bus.calc_c;
        resp_rco_reg <= bus.calc_rco;
        resp_id_reg  <= op_id_reg;
      end
      if (resp_fire) count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign bus.calc_a     = drive_calc ? op_a_reg    : '0;
  assign bus.calc_b     = drive_calc ? op_b_reg    : '0;
  assign bus.calc_modo  = drive_calc ? op_modo_reg : 2'b00;
  assign bus.resp_valid = (state_reg == ST_RESP);
  assign bus.resp_c     = resp_c_reg;
  assign bus.resp_rco   = resp_rco_reg;
  assign bus.resp_id    = resp_id_reg;
  assign busy           = (state_reg != ST_IDLE);
  assign op_count       = count_reg;

endmodule

// File: tb/tb_calc_arbiter.sv
// Directed bench for calc_arbiter with a behavioural registered calculator
// attached; op_count is built 2 bits wide so wrap-around is reachable.
module tb_calc_arbiter;
  import calc_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [1:0] op_count;

  calc_arbiter_if #(.DATA_W(4)) bus ();

  calc_arbiter #(.DATA_W(4), .CNT_W(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] calc_fn(input logic [3:0] a, input logic [3:0] b,
                                         input logic [1:0] m);
    logic [7:0] p;
    p = {4'b0, a} * {4'b0, b};
    case (m)
      MODO_ADD: return {1'b0, a} + {1'b0, b};
      MODO_SUB: return {1'b0, a} - {1'b0, b};
      MODO_MUL: return p[4:0];
      default:  return {a, 1'b0};
    endcase
  endfunction

  // Calculator: registers {rco, c} every cycle from its current operands.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) {bus.calc_rco, bus.calc_c} <= 5'b0;
    else     {bus.calc_rco, bus.calc_c} <= calc_fn(bus.calc_a, bus.calc_b, bus.calc_modo);
  end

  int         errors = 0;
  int         checks = 0;
  logic [1:0] exp_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic       id;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] modo;
    logic [3:0] c;
    logic       rco;
  } vec_t;

  vec_t vecs[6];

  // Present a request and return at the negedge after its accept edge (ISSUE).
  task automatic start_op(input logic id, input logic [3:0] a, input logic [3:0] b,
                          input logic [1:0] m);
    int k;
    @(negedge clk);
    if (id == 1'b0) begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_modo = m;
    end else begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_modo = m;
    end
    bus.req_valid[id] = 1'b1;
    #1;
    k = 0;
    while (!bus.req_ready[id] && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("req_ready_wait", 32'(bus.req_ready[id]), 1);
    @(negedge clk);
    bus.req_valid[id] = 1'b0;
    check("issue_calc_a", 32'(bus.calc_a), 32'(a));
    check("issue_calc_b", 32'(bus.calc_b), 32'(b));
    check("issue_calc_modo", 32'(bus.calc_modo), 32'(m));
    check("issue_busy", 32'(busy), 1);
    check("issue_req_ready", 32'(bus.req_ready), 0);
  endtask

  // From ISSUE: verify two-cycle latency, the response and the count.
  task automatic finish_op(input logic id, input logic [3:0] c, input logic rco);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    check("capture_no_resp", 32'(bus.resp_valid), 0);
    @(negedge clk);
    check("resp_valid", 32'(bus.resp_valid), 1);
    check("resp_id", 32'(bus.resp_id), 32'(id));
    check("resp_c", 32'(bus.resp_c), 32'(c));
    check("resp_rco", 32'(bus.resp_rco), 32'(rco));
    $display("op id=%0d c=%h rco=%0d (exp c=%h rco=%0d)", bus.resp_id, bus.resp_c,
             bus.resp_rco, c, rco);
    @(negedge clk);
    exp_count = exp_count + 2'd1;
    check("idle_busy", 32'(busy), 0);
    check("op_count", 32'(op_count), 32'(exp_count));
  endtask

  initial begin
    int   gseq[$];
    int   rseq[$];
    int   cseq[$];
    int   both_high;
    int   seen;

    vecs[0] = '{1'b0, 4'h7, 4'h9, MODO_ADD, 4'h0, 1'b1};
    vecs[1] = '{1'b1, 4'h3, 4'h5, MODO_SUB, 4'hE, 1'b1};
    vecs[2] = '{1'b1, 4'h6, 4'h6, MODO_MUL, 4'h4, 1'b0};
    vecs[3] = '{1'b0, 4'h9, 4'h0, MODO_SHL, 4'h2, 1'b1};
    vecs[4] = '{1'b1, 4'hF, 4'h1, MODO_ADD, 4'h0, 1'b1};
    vecs[5] = '{1'b0, 4'h2, 4'h3, MODO_MUL, 4'h6, 1'b0};

    // Reset with both requesters already valid.
    rst = 1'b1;
    bus.req_valid = 2'b11;
    bus.req0_a = 4'h1; bus.req0_b = 4'h1; bus.req0_modo = MODO_ADD;
    bus.req1_a = 4'h2; bus.req1_b = 4'h2; bus.req1_modo = MODO_ADD;
    bus.resp_ready = 1'b1;
    exp_count = 2'd0;
    #3;
    check("rst_req_ready", 32'(bus.req_ready), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_resp_valid", 32'(bus.resp_valid), 0);
    check("rst_op_count", 32'(op_count), 0);
    check("rst_calc_a", 32'(bus.calc_a), 0);
    check("rst_resp_c", 32'(bus.resp_c), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;

    // Both valid and held: grants must alternate starting with requester 0.
    both_high = 0;
    for (int cyc = 0; cyc < 24 && gseq.size() < 4; cyc++) begin
      if (bus.req_ready == 2'b11) both_high++;
      if (bus.req_ready != 2'b00) gseq.push_back(bus.req_ready[1] ? 1 : 0);
      if (bus.resp_valid) begin
        rseq.push_back(int'(bus.resp_id));
        cseq.push_back(int'(bus.resp_c));
        $display("op id=%0d c=%h rco=%0d (round-robin)", bus.resp_id, bus.resp_c, bus.resp_rco);
      end
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
    for (int k = 0; k < 10 && busy; k++) begin
      if (bus.resp_valid) begin
        rseq.push_back(int'(bus.resp_id));
        cseq.push_back(int'(bus.resp_c));
        $display("op id=%0d c=%h rco=%0d (round-robin)", bus.resp_id, bus.resp_c, bus.resp_rco);
      end
      @(negedge clk);
    end
    check("rr_ready_onehot", 32'(both_high), 0);
    check("rr_grant_count", 32'(gseq.size()), 4);
    check("rr_resp_count", 32'(rseq.size()), 4);
    for (int i = 0; i < gseq.size(); i++) check("rr_grant_order", 32'(gseq[i]), 32'(i % 2));
    for (int i = 0; i < rseq.size(); i++) begin
      check("rr_resp_id", 32'(rseq[i]), 32'(i % 2));
      check("rr_resp_c", 32'(cseq[i]), (i % 2 == 0) ? 32'd2 : 32'd4);
    end
    check("rr_op_count", 32'(op_count), 0);

    // Fresh reset, then the table of single-requester operations.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_count = 2'd0;
    for (int i = 0; i < 6; i++) begin
      start_op(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].modo);
      finish_op(vecs[i].id, vecs[i].c, vecs[i].rco);
      if (i == 4) check("count_wrap_after_5", 32'(op_count), 1);
    end

    // Response backpressure with the other requester waiting.
    start_op(1'b1, 4'h5, 4'h2, MODO_SUB);
    bus.resp_ready = 1'b0;
    bus.req0_a = 4'h4; bus.req0_b = 4'h4; bus.req0_modo = MODO_ADD;
    bus.req_valid[0] = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      check("bp_resp_valid", 32'(bus.resp_valid), 1);
      check("bp_resp_c", 32'(bus.resp_c), 32'h3);
      check("bp_resp_rco", 32'(bus.resp_rco), 0);
      check("bp_resp_id", 32'(bus.resp_id), 1);
      check("bp_req_ready", 32'(bus.req_ready), 0);
      check("bp_op_count", 32'(op_count), 32'(exp_count));
      @(negedge clk);
    end
    $display("op id=%0d c=%h rco=%0d (after backpressure)", bus.resp_id, bus.resp_c, bus.resp_rco);
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.req_valid[0] = 1'b0;
    exp_count = exp_count + 2'd1;
    check("bp_release_busy", 32'(busy), 0);
    check("bp_release_count", 32'(op_count), 32'(exp_count));

    // Asynchronous reset in the middle of CAPTURE.
    start_op(1'b0, 4'h3, 4'h4, MODO_ADD);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_resp_valid", 32'(bus.resp_valid), 0);
    check("mid_rst_calc_a", 32'(bus.calc_a), 0);
    check("mid_rst_calc_b", 32'(bus.calc_b), 0);
    check("mid_rst_calc_modo", 32'(bus.calc_modo), 0);
    check("mid_rst_resp_c", 32'(bus.resp_c), 0);
    check("mid_rst_resp_id", 32'(bus.resp_id), 0);
    check("mid_rst_resp_rco", 32'(bus.resp_rco), 0);
    check("mid_rst_req_ready", 32'(bus.req_ready), 0);
    check("mid_rst_op_count", 32'(op_count), 0);
    exp_count = 2'd0;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (bus.resp_valid || busy) seen++;
    end
    check("mid_rst_no_resp", 32'(seen), 0);
    start_op(1'b0, 4'h1, 4'h1, MODO_ADD);
    finish_op(1'b0, 4'h2, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
